microwave_cook_sequencer: RTL



---
 rtl/microwave_cook_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/microwave_cook_sequencer.sv
// microwave_cook_sequencer: multi-stage keypad cook controller. Counts each stage down
// in BCD on an internal 1 s tick and duty-cycles the magnetron per stage power level.
module microwave_cook_sequencer #(
    parameter int STAGES   = 2,
    parameter int TICK_DIV = 1000,
    parameter int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          door_closed,
    input  logic          key_valid,
    input  logic [3:0]    key_digit,
    input  logic          power_key,
    input  logic          stage_key,
    output logic          mag_on,
    output logic          running,
    output logic [SW-1:0] stage,
    output logic [3:0]    sec_ones,
    output logic [3:0]    sec_tens,
    output logic [3:0]    mins,
    output logic          done
);

    localparam int            TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_COOK, ST_PAUSE, ST_DONE} state_t;

    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_time_t;

    // One-second BCD decrement; only ever applied to a non-zero time.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.ones != 4'd0) begin
            r.ones = t.ones - 4'd1;
        end else begin
            r.ones = 4'd9;
            if (t.tens != 4'd0) begin
                r.tens = t.tens - 4'd1;
            end else begin
                r.tens = 4'd5;
                r.mins = t.mins - 4'd1;
            end
        end
        return r;
    endfunction

    state_t        state, state_next;
    bcd_time_t     times [STAGES];
    logic [3:0]    power [STAGES];
    logic [SW-1:0] edit_stage, active_stage, stage_sel;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    slot_cnt;
    logic          power_pending;
    logic          done_q;

    logic          any_nz, has_next;
    logic [SW-1:0] first_nz, next_nz;
    bcd_time_t     dec_time;
    logic          tick_wrap, key_ok;
    logic          do_clear, do_start, do_resume, do_count, do_edit;
    logic          do_advance, do_finish, do_exit;

    assign dec_time  = bcd_dec(times[active_stage]);
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign key_ok    = key_valid && (key_digit <= 4'd9);

    // Scanning downwards leaves the lowest qualifying index in each result.
    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        any_nz   = 1'b0;
        has_next = 1'b0;
        first_nz = '0;
        next_nz  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (times[i] != '0) begin
                any_nz   = 1'b1;
                first_nz = SW'(i);
                if (i > int'(active_stage)) begin
                    has_next = 1'b1;
                    next_nz  = SW'(i);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_start   = 1'b0;
        do_resume  = 1'b0;
        do_count   = 1'b0;
        do_edit    = 1'b0;
        do_advance = 1'b0;
        do_finish  = 1'b0;
        do_exit    = 1'b0;
        if (clear) begin
            do_clear   = 1'b1;
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Stop and start both outrank keys, even when the start is refused.
                    do_edit = !stop && !start;
                    if (start && !stop && door_closed && any_nz) begin
                        do_start   = 1'b1;
                        state_next = ST_COOK;
                    end
                end
                ST_COOK: begin
                    if (!door_closed || stop) begin
                        state_next = ST_PAUSE;
                    end else begin
                        do_count = 1'b1;
                        if (tick_wrap && dec_time == '0) begin
                            if (has_next) begin
                                do_advance = 1'b1;
                            end else begin
                                do_finish  = 1'b1;
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (door_closed) begin
                        if (stop) begin
                            do_clear   = 1'b1;
                            state_next = ST_IDLE;
                        end else if (start) begin
                            do_resume  = 1'b1;
                            state_next = ST_COOK;
                        end
                    end
                end
                ST_DONE: begin
                    if (stop || start || key_valid || power_key || stage_key) begin
                        do_exit    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: the stage tables are ordinary flops, reset here because reset must leave every
    // stage at 0:00 and power 10; they are not meant to map onto RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                times[i] <= '0;
                power[i] <= 4'd10;
            end
            edit_stage    <= '0;
            active_stage  <= '0;
            tick_cnt      <= '0;
            slot_cnt      <= '0;
            power_pending <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= do_finish;
            if (do_clear) begin
                for (int i = 0; i < STAGES; i++) begin
                    times[i] <= '0;
                    power[i] <= 4'd10;
                end
                edit_stage    <= '0;
                active_stage  <= '0;
                tick_cnt      <= '0;
                slot_cnt      <= '0;
                power_pending <= 1'b0;
            end else begin
                if (do_edit) begin
                    if (key_ok) begin
                        if (power_pending) begin
                            power[edit_stage] <= (key_digit == 4'd0) ? 4'd10 : key_digit;
                        end else if (times[edit_stage].ones <= 4'd5) begin
                            times[edit_stage] <= {times[edit_stage].tens, times[edit_stage].ones, key_digit};
                        end
                    end
                    if (power_key)   power_pending <= 1'b1;
                    else if (key_ok) power_pending <= 1'b0;
                    if (stage_key) edit_stage <= (edit_stage == STAGE_LAST) ? '0 : edit_stage + 1'b1;
                end
                if (do_start) begin
                    active_stage  <= first_nz;
                    tick_cnt      <= '0;
                    slot_cnt      <= '0;
                    power_pending <= 1'b0;
                end
                if (do_resume) tick_cnt <= '0;
                if (do_count) begin
                    if (tick_wrap) begin
                        times[active_stage] <= dec_time;
                        tick_cnt            <= '0;
                        slot_cnt            <= (slot_cnt == 4'd9) ? '0 : slot_cnt + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                    if (do_advance) begin
                        active_stage <= next_nz;
                        slot_cnt     <= '0;
                    end
                end
                if (do_exit) begin
                    edit_stage    <= '0;
                    power_pending <= 1'b0;
                end
            end
        end
    end

    assign stage_sel                  = (state == ST_IDLE) ? edit_stage : active_stage;
    assign stage                      = stage_sel;
    assign {mins, sec_tens, sec_ones} = times[stage_sel];
    assign running                    = (state == ST_COOK);
    assign done                       = done_q;
    assign mag_on = (state == ST_COOK) && door_closed && (slot_cnt < power[active_stage]);

endmodule
